// File: rtl/untrusted_mem_responder.sv
// untrusted_mem_responder: decodes word requests onto ROM/RAM macros and answers each with a fixed two-cycle latency,
// so decode errors cannot be told apart from hits by timing.
module untrusted_mem_responder #(
  parameter logic [31:0] RomAddr = 32'h0000_0000,
  parameter logic [31:0] RomMask = 32'h0000_3FFF,
  parameter logic [31:0] RamAddr = 32'h5000_0000,
  parameter logic [31:0] RamMask = 32'h0001_FFFF,
  parameter int unsigned ErrCntW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_addr_i,
  input  logic               req_we_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [3:0]         req_be_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               rom_req_o,
  output logic [11:0]        rom_addr_o,
  input  logic [31:0]        rom_rdata_i,
  output logic               ram_req_o,
  output logic               ram_we_o,
  output logic [14:0]        ram_addr_o,
  output logic [31:0]        ram_wdata_o,
  output logic [3:0]         ram_be_o,
  input  logic [31:0]        ram_rdata_i,
  output logic [ErrCntW-1:0] err_count_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic err_q, err_d, rd_rom_q, rd_rom_d, rd_ram_q, rd_ram_d;
  logic [31:0] rdata_q, rdata_d;
  logic [ErrCntW-1:0] cnt_q, cnt_d;
  logic rom_hit, ram_hit, dec_err, accept, rsp_done;
  logic [31:0] rom_off, ram_off;

  assign rom_hit = (req_addr_i & ~RomMask) == RomAddr;
  assign ram_hit = (req_addr_i & ~RamMask) == RamAddr;
  assign dec_err = (req_addr_i[1:0] != 2'b00) | ~(rom_hit | ram_hit) | (rom_hit & req_we_i)
                 | (req_we_i & (req_be_i == 4'b0000));
  assign rom_off = req_addr_i & RomMask;
  assign ram_off = req_addr_i & RamMask;
  assign accept = (state_q == IDLE) & req_valid_i;
  assign rsp_done = (state_q == RESP) & rsp_ready_i;
  assign rom_addr_o = rom_off[13:2];
  assign ram_addr_o = ram_off[16:2];
  assign ram_wdata_o = req_wdata_i;
  assign ram_be_o = req_be_i;
  assign rsp_rdata_o = rdata_q;
  assign err_count_o = cnt_q;

  always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

  always_comb begin
    state_d = accept ? WAIT : (state_q == WAIT) ? RESP : (state_q == RESP && !rsp_ready_i) ? RESP : IDLE;
  end

  always_comb begin
    req_ready_o = state_q == IDLE;
    rsp_valid_o = state_q == RESP;
    rsp_err_o = rsp_valid_o & err_q;
    rom_req_o = accept & ~dec_err & rom_hit;
    ram_req_o = accept & ~dec_err & ram_hit;
    ram_we_o = ram_req_o & req_we_i;
  end

  // WAIT is the only cycle the macros' read data is valid; writes and errors answer with zero.
  always_comb begin
    err_d = accept ? dec_err : err_q;
    rd_rom_d = accept ? rom_hit & ~dec_err & ~req_we_i : rd_rom_q;
    rd_ram_d = accept ? ram_hit & ~dec_err & ~req_we_i : rd_ram_q;
    rdata_d = (state_q != WAIT) ? rdata_q : rd_rom_q ? rom_rdata_i : rd_ram_q ? ram_rdata_i : '0;
    cnt_d = (rsp_done && err_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      rd_rom_q <= 1'b0;
      rd_ram_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      rd_rom_q <= rd_rom_d;
      rd_ram_q <= rd_ram_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
